mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_mem_access.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access -- MEM-stage load/store unit bridging a pipeline op to a simple
// word-wide request/grant/rvalid bus.
//
// Build option: define MEM_UNALIGNED_EN to support LWL/LWR/SWL/SWR (sizes WL
// and WR). Without it those sizes report addr_err and the merge logic is
// not built.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready op handshake; req_ready is high only in IDLE
//   mem_type            0 NOOP, 1 LOAD, 2 STORE
//   mem_size            0 B, 1 H, 2 W, 3 WL, 4 WR
//   unsigned_flag       zero-extend B/H loads
//   addr, rt_val        byte address, store data / LWL-LWR merge source
//   resp_valid          one-cycle completion pulse
//   resp_data           load result (0 for stores, NOOPs and errors)
//   addr_err            qualifies resp_valid: misaligned access
//   bus_*               registered request side (word address, byte enables,
//                       write data), bus_gnt / bus_rvalid / bus_rdata inputs
// ---------------------------------------------------------------------------
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  mem_type,
  input  logic [2:0]  mem_size,
  input  logic        unsigned_flag,
  input  logic [31:0] addr,
  input  logic [31:0] rt_val,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        addr_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  localparam logic [1:0] T_LOAD  = 2'd1;
  localparam logic [1:0] T_STORE = 2'd2;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
`ifdef MEM_UNALIGNED_EN
  localparam logic [2:0] SZ_WL = 3'd3;
  localparam logic [2:0] SZ_WR = 3'd4;
`endif

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  // Unsupported sizes fall into the default and are reported as misaligned.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] a);
    logic m;
    case (size)
      SZ_B:    m = 1'b0;
      SZ_H:    m = a[0];
      SZ_W:    m = (a != 2'd0);
`ifdef MEM_UNALIGNED_EN
      SZ_WL,
      SZ_WR:   m = 1'b0;
`endif
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << a;
      SZ_H:    be = a[1] ? 4'b1100 : 4'b0011;
`ifdef MEM_UNALIGNED_EN
      // ~a == 3-a for a 2-bit offset
      SZ_WL:   be = 4'b1111 >> (~a);
      SZ_WR:   be = 4'b1111 << a;
`endif
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] size, input logic [1:0] a,
                                             input logic [31:0] rt);
    logic [31:0] d;
    case (size)
      SZ_B:    d = {4{rt[7:0]}};
      SZ_H:    d = {2{rt[15:0]}};
`ifdef MEM_UNALIGNED_EN
      SZ_WL:   d = rt >> {~a, 3'b000};
      SZ_WR:   d = rt << {a, 3'b000};
`endif
      default: d = rt;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [2:0] size, input logic [1:0] a,
                                           input logic uns, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (size)
      SZ_B:    r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

`ifdef MEM_UNALIGNED_EN
  // LWL: top (a+1) bytes come from the word's low bytes, rest from rt.
  // LWR: low (4-a) bytes come from word bytes a..3, rest from rt.
  function automatic logic [31:0] merge_load(input logic [2:0] size, input logic [1:0] a,
                                             input logic [31:0] rd, input logic [31:0] rt);
    logic [31:0] r;
    if (size == SZ_WL) begin
      case (a)
        2'd0:    r = {rd[7:0],  rt[23:0]};
        2'd1:    r = {rd[15:0], rt[15:0]};
        2'd2:    r = {rd[23:0], rt[7:0]};
        default: r = rd;
      endcase
    end else begin
      case (a)
        2'd0:    r = rd;
        2'd1:    r = {rt[31:24], rd[31:8]};
        2'd2:    r = {rt[31:16], rd[31:16]};
        default: r = {rt[31:8],  rd[31:24]};
      endcase
    end
    return r;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        addr_err_q, addr_err_d;
  // Fields latched at accept for load formatting
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  size_q, size_d;
  logic        uns_q, uns_d;
`ifdef MEM_UNALIGNED_EN
  logic [31:0] rt_q, rt_d;
`endif

  logic accept;
  logic is_mem_op;
  logic misaligned;

  assign accept     = (state_q == IDLE) && req_valid;
  assign is_mem_op  = (mem_type == T_LOAD) || (mem_type == T_STORE);
  assign misaligned = is_misaligned(mem_size, addr[1:0]);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_mem_op && !misaligned) state_d = ADDR;
      ADDR: if (bus_gnt) state_d = bus_we_q ? IDLE : DATA;
      DATA: if (bus_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    resp_valid_d = 1'b0;
    resp_data_d  = 32'd0;
    addr_err_d   = 1'b0;
    lane_d       = lane_q;
    size_d       = size_q;
    uns_d        = uns_q;
`ifdef MEM_UNALIGNED_EN
    rt_d         = rt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem_op) begin
            resp_valid_d = 1'b1;
          end else if (misaligned) begin
            resp_valid_d = 1'b1;
            addr_err_d   = 1'b1;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = (mem_type == T_STORE);
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_be_d    = byte_en(mem_size, addr[1:0]);
            bus_wdata_d = (mem_type == T_STORE) ?
                          store_data(mem_size, addr[1:0], rt_val) : 32'd0;
            lane_d      = addr[1:0];
            size_d      = mem_size;
            uns_d       = unsigned_flag;
`ifdef MEM_UNALIGNED_EN
            rt_d        = rt_val;
`endif
          end
        end
      end
      ADDR: begin
        if (bus_gnt) begin
          bus_req_d    = 1'b0;
          resp_valid_d = bus_we_q;
        end
      end
      DATA: begin
        if (bus_rvalid) begin
          resp_valid_d = 1'b1;
`ifdef MEM_UNALIGNED_EN
          if (size_q == SZ_WL || size_q == SZ_WR)
            resp_data_d = merge_load(size_q, lane_q, bus_rdata, rt_q);
          else
            resp_data_d = fmt_load(size_q, lane_q, uns_q, bus_rdata);
`else
          resp_data_d = fmt_load(size_q, lane_q, uns_q, bus_rdata);
`endif
        end
      end
      default: ;
    endcase
  end

  // Output / latched-field registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_be_q     <= 4'd0;
      bus_wdata_q  <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      addr_err_q   <= 1'b0;
      lane_q       <= 2'd0;
      size_q       <= 3'd0;
      uns_q        <= 1'b0;
`ifdef MEM_UNALIGNED_EN
      rt_q         <= 32'd0;
`endif
    end else begin
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      addr_err_q   <= addr_err_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
`ifdef MEM_UNALIGNED_EN
      rt_q         <= rt_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign addr_err   = addr_err_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access -- directed plus randomized bench for mem_access. Expected
// bus requests and load results come from a byte-lane reference model.
// Honours MEM_UNALIGNED_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  mem_type;
  logic [2:0]  mem_size;
  logic        unsigned_flag;
  logic [31:0] addr;
  logic [31:0] rt_val;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        addr_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  // values seen on the last transaction, for spec-literal checks
  logic [31:0] obs_addr, obs_wdata, obs_resp;
  logic [3:0]  obs_be;

  mem_access dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_type(mem_type), .mem_size(mem_size), .unsigned_flag(unsigned_flag),
    .addr(addr), .rt_val(rt_val),
    .resp_valid(resp_valid), .resp_data(resp_data), .addr_err(addr_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ------------------------- reference model --------------------------------
  function automatic bit m_err(int sz, int a);
    case (sz)
      0: return 1'b0;
      1: return (a % 2) != 0;
      2: return a != 0;
`ifdef MEM_UNALIGNED_EN
      3, 4: return 1'b0;
`endif
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] m_be(int sz, int a);
    int lo, hi;
    logic [3:0] be;
    case (sz)
      0: begin lo = a; hi = a; end
      1: begin lo = a; hi = a + 1; end
      3: begin lo = 0; hi = a; end
      4: begin lo = a; hi = 3; end
      default: begin lo = 0; hi = 3; end
    endcase
    be = 4'd0;
    for (int i = 0; i < 4; i++) if (i >= lo && i <= hi) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(int sz, int a, logic [31:0] rt);
    case (sz)
      0: return 32'(rt[7:0]) * 32'h0101_0101;
      1: return 32'(rt[15:0]) * 32'h0001_0001;
      3: return rt >> (8 * (3 - a));
      4: return rt << (8 * a);
      default: return rt;
    endcase
  endfunction

  function automatic logic [31:0] m_load(int sz, int a, bit uns, logic [31:0] rd,
                                         logic [31:0] rt);
    logic [31:0] v;
    logic [63:0] m;
    int n;
    v = rd;
    case (sz)
      0: begin
        v = (rd >> (8 * a)) & 32'hFF;
        if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end
      1: begin
        v = (rd >> (8 * (a & 2))) & 32'hFFFF;
        if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end
      3: begin
        n = 3 - a;
        m = (64'd1 << (8 * n)) - 64'd1;
        v = 32'((64'(rd) << (8 * n)) | (64'(rt) & m));
      end
      4: begin
        n = 4 - a;
        m = (64'd1 << (8 * n)) - 64'd1;
        v = 32'((64'(rt) & ~m) | 64'(rd >> (8 * a)));
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // ------------------------- transaction driver -----------------------------
  // Called at a negedge; returns at the negedge where the response is visible,
  // so the next call exercises accept-in-response-cycle.
  task automatic do_op(input int typ, input int sz, input logic [31:0] a32,
                       input logic [31:0] rt, input bit uns, input logic [31:0] rd,
                       input int gd, input int rdl);
    int a;
    bit err;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ad;
    a    = int'(a32[1:0]);
    err  = (typ != 0) && m_err(sz, a);
    e_be = m_be(sz, a);
    e_wd = (typ == 2) ? m_wdata(sz, a, rt) : 32'd0;
    e_ad = a32 & 32'hFFFF_FFFC;

    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; mem_type = 2'(typ); mem_size = 3'(sz);
    addr = a32; rt_val = rt; unsigned_flag = uns;
    @(negedge clk);
    // later input changes must have no effect
    req_valid = 1'b0; mem_type = 2'($urandom_range(0, 3)); mem_size = 3'($urandom);
    addr = $urandom; rt_val = $urandom; unsigned_flag = 1'($urandom);

    if (typ == 0 || err) begin
      chk("short_resp_valid", resp_valid, 1'b1);
      chk("short_addr_err", addr_err, err);
      chk("short_resp_data", resp_data, 32'd0);
      chk("short_no_bus_req", bus_req, 1'b0);
      chk("short_ready", req_ready, 1'b1);
      obs_resp = resp_data;
      return;
    end

    chk("bus_req_up", {resp_valid, bus_req, bus_we}, {1'b0, 1'b1, typ == 2});
    chk("bus_addr", bus_addr, e_ad);
    chk("bus_be", bus_be, e_be);
    if (typ == 2) chk("bus_wdata", bus_wdata, e_wd);
    obs_addr = bus_addr; obs_be = bus_be; obs_wdata = bus_wdata;

    for (int i = 0; i < gd; i++) begin
      bus_gnt = 1'b0;
      @(negedge clk);
      chk("hold_ctrl", {resp_valid, req_ready, bus_req, bus_we, bus_be},
          {1'b0, 1'b0, 1'b1, typ == 2, e_be});
      chk("hold_addr", bus_addr, e_ad);
      if (typ == 2) chk("hold_wdata", bus_wdata, e_wd);
    end

    bus_gnt = 1'b1;
    if (typ == 1) begin
      bus_rvalid = 1'b1;         // must be ignored in the grant cycle
      bus_rdata  = ~rd;
    end
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = 1'b0;

    if (typ == 2) begin
      chk("st_resp_valid", {resp_valid, addr_err, bus_req}, {1'b1, 1'b0, 1'b0});
      chk("st_resp_data", resp_data, 32'd0);
      obs_resp = resp_data;
      return;
    end

    chk("ld_after_gnt", {resp_valid, bus_req, req_ready}, 3'b000);
    for (int i = 0; i < rdl; i++) begin
      @(negedge clk);
      chk("ld_wait", {resp_valid, req_ready}, 2'b00);
    end
    bus_rvalid = 1'b1; bus_rdata = rd;
    @(negedge clk);
    bus_rvalid = 1'b0; bus_rdata = $urandom;
    chk("ld_resp_valid", {resp_valid, addr_err}, 2'b10);
    chk("ld_resp_data", resp_data, m_load(sz, a, uns, rd, rt));
    obs_resp = resp_data;
  endtask

  // ------------------------- stimulus ---------------------------------------
  initial begin
    rst = 1'b1; req_valid = 1'b0; mem_type = 2'd0; mem_size = 3'd0;
    unsigned_flag = 1'b0; addr = 32'd0; rt_val = 32'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_ctrl", {req_ready, resp_valid, addr_err, bus_req, bus_we}, 5'b10000);
    chk("rst_data", {resp_data, bus_wdata}, 64'd0);
    chk("rst_bus", {bus_addr, bus_be}, 36'd0);
    rst = 1'b0;
    @(negedge clk);

    // load byte, sign extended
    do_op(1, 0, 32'h0000_1003, 32'h5555_5555, 1'b0, 32'h80FF_1234, 0, 1);
    chk("lb_addr", obs_addr, 32'h0000_1000);
    chk("lb_be", obs_be, 4'b1000);
    chk("lb_data", obs_resp, 32'hFFFF_FF80);

    // store half with a 3-cycle grant delay
    do_op(2, 1, 32'h0000_2002, 32'hAAAA_BEEF, 1'b0, 32'd0, 3, 0);
    chk("sh_be", obs_be, 4'b1100);
    chk("sh_wdata", obs_wdata, 32'hBEEF_BEEF);
    @(negedge clk);
    chk("sh_single_pulse", resp_valid, 1'b0);

    // misaligned word load
    do_op(1, 2, 32'h0000_3001, 32'd0, 1'b0, 32'd0, 0, 0);
    @(negedge clk);
    chk("lw_mis_pulse_end", {resp_valid, addr_err, bus_req}, 3'b000);

    // NOOP
    do_op(0, 2, 32'h0000_0040, 32'h1234_5678, 1'b0, 32'd0, 0, 0);

    // unsigned half load, back-to-back
    do_op(1, 1, 32'h0000_5002, 32'd0, 1'b1, 32'h8001_7FFE, 1, 0);
    chk("lhu_data", obs_resp, 32'h0000_8001);

`ifdef MEM_UNALIGNED_EN
    do_op(1, 3, 32'h0000_4001, 32'h1122_3344, 1'b0, 32'hAABB_CCDD, 0, 0);
    chk("lwl_data", obs_resp, 32'hCCDD_3344);
    do_op(1, 4, 32'h0000_4001, 32'h1122_3344, 1'b0, 32'hAABB_CCDD, 2, 1);
    chk("lwr_data", obs_resp, 32'h11AA_BBCC);
`else
    do_op(1, 3, 32'h0000_4000, 32'h1122_3344, 1'b0, 32'hAABB_CCDD, 0, 0);
    chk("wl_disabled_err", addr_err, 1'b1);
    do_op(2, 4, 32'h0000_4000, 32'h1122_3344, 1'b0, 32'd0, 0, 0);
    chk("wr_disabled_err", addr_err, 1'b1);
`endif

    // randomized ops
    for (int n = 0; n < 200; n++) begin
      do_op($urandom_range(0, 2), $urandom_range(0, 4), $urandom, $urandom,
            1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    @(negedge clk);

    // reset while a load waits in the data phase
    chk("pre_rst_ready", req_ready, 1'b1);
    req_valid = 1'b1; mem_type = 2'd1; mem_size = 3'd2; addr = 32'h0000_6000;
    @(negedge clk);
    req_valid = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("in_data_phase", {req_ready, bus_req}, 2'b00);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", {req_ready, resp_valid, addr_err, bus_req, bus_we}, 5'b10000);
    chk("rst_mid_data", {resp_data, bus_addr}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("abandoned_rvalid", {resp_valid, req_ready, bus_req}, 3'b010);
    @(negedge clk);
    chk("abandoned_quiet", {resp_valid, req_ready}, 2'b01);

    // recovery
    do_op(1, 0, 32'h0000_7001, 32'd0, 1'b1, 32'h0000_9A00, 0, 0);
    chk("recover_data", obs_resp, 32'h0000_009A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
